// File: rtl/perm_deal_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | perm_deal_if : deal request/grant and nibble-stream bundle               |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface perm_deal_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
);
  logic [63:0]        seq_all;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [3:0]         out_data;
  logic [3:0]         out_idx;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;
  logic [CNT_W-1:0]   deal_cnt;
  logic               perm_err;

  modport master (
    input  seq_all, req, out_ready,
    output gnt, out_data, out_idx, out_valid, out_last, busy, deal_cnt, perm_err
  );

  modport slave (
    output seq_all, req, out_ready,
    input  gnt, out_data, out_idx, out_valid, out_last, busy, deal_cnt, perm_err
  );
endinterface
`default_nettype wire

// File: rtl/perm_deal_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | perm_deal_ctrl : round-robin dealer of permutation snapshots, one nibble |
// | per handshake. Optional snapshot checker enabled by PERM_CHECK_EN.       |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module perm_deal_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  wire logic    clk,
  input  wire logic    rst,
  perm_deal_if.master  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr;
  logic [63:0]        r_snap;
  logic [NUM_REQ-1:0] r_gnt;
  logic [3:0]         r_idx;
  logic [3:0]         r_data;
  logic               r_valid;
  logic               r_last;
  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [NUM_REQ-1:0] w_win_oh;
  logic               w_abort;
  logic               w_done;
  logic [3:0]         w_next_idx;

  function automatic logic [PTR_W-1:0] f_wrap(input int v);
    f_wrap = PTR_W'(v % NUM_REQ);
  endfunction

  // Search upward from the last winner so every requester gets its turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && bus.req[f_wrap(int'(r_rr) + k)]) begin
        w_found = 1'b1;
        w_win   = f_wrap(int'(r_rr) + k);
      end
    end
  end

  assign w_win_oh   = NUM_REQ'(1) << w_win;
  assign w_abort    = ((r_gnt & bus.req) == '0);
  assign w_done     = !w_abort && bus.out_ready && (r_idx == 4'd15);
  assign w_next_idx = r_idx + 4'd1;

`ifdef PERM_CHECK_EN
  logic [15:0] w_seen;
  logic        w_is_perm;
  logic        r_perm_err;

  // Sixteen nibbles hitting all sixteen values means each appears exactly once.
  always_comb begin
    w_seen = '0;
    for (int i = 0; i < 16; i++) begin
      w_seen[bus.seq_all[4*i +: 4]] = 1'b1;
    end
    w_is_perm = &w_seen;
  end

  assign bus.perm_err = r_perm_err;
`else
  assign bus.perm_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rr    <= PTR_W'(NUM_REQ - 1);
      r_snap  <= '0;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
`ifdef PERM_CHECK_EN
      r_perm_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_STREAM;
            r_snap  <= bus.seq_all;
            r_gnt   <= w_win_oh;
            r_rr    <= w_win;
            r_idx   <= '0;
            r_data  <= bus.seq_all[3:0];
            r_last  <= 1'b0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
`ifdef PERM_CHECK_EN
            if (!w_is_perm) r_perm_err <= 1'b1;
`endif
          end
        end
        S_STREAM: begin
          // A dropped request wins over a handshake on the same edge.
          if (w_abort || w_done) begin
            if (w_done) r_cnt <= r_cnt + CNT_W'(1);
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
          end else if (bus.out_ready) begin
            r_idx  <= w_next_idx;
            r_data <= r_snap[{w_next_idx, 2'b00} +: 4];
            r_last <= (w_next_idx == 4'd15);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.out_data  = r_data;
  assign bus.out_idx   = r_idx;
  assign bus.out_valid = r_valid;
  assign bus.out_last  = r_last;
  assign bus.busy      = r_busy;
  assign bus.deal_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_perm_deal_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_perm_deal_ctrl : directed bench with a behavioural deal model          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_perm_deal_ctrl;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 4;   // narrow counter so the wrap is reachable quickly
  localparam logic [63:0] P_GOOD = 64'hFEDCBA9876543210;
  localparam logic [63:0] P_BAD  = 64'h0EDCBA9876543210;
  localparam logic [63:0] P_ALT  = 64'h0123456789ABCDEF;
`ifdef PERM_CHECK_EN
  localparam logic EXP_BAD_PE = 1'b1;
`else
  localparam logic EXP_BAD_PE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  perm_deal_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

  perm_deal_ctrl #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a deal is "who holds it, which element is on show, what was captured".
  logic        m_busy = 1'b0;
  int          m_win  = 0;
  int          m_idx  = 0;
  int          m_rr   = NUM_REQ - 1;
  int          m_cnt  = 0;
  logic        m_perm = 1'b0;
  logic [63:0] m_snap = '0;

  function automatic bit is_perm(input logic [63:0] v);
    int hits[16];
    foreach (hits[i]) hits[i] = 0;
    for (int i = 0; i < 16; i++) hits[v[4*i +: 4]]++;
    foreach (hits[i]) if (hits[i] != 1) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_idx = 0; m_rr = NUM_REQ - 1; m_cnt = 0; m_perm = 1'b0; m_win = 0;
    end else if (!m_busy) begin
      if (bus.req != '0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (bus.req[(m_rr + k) % NUM_REQ]) begin
            m_win = (m_rr + k) % NUM_REQ;
            break;
          end
        end
        m_rr = m_win; m_snap = bus.seq_all; m_idx = 0; m_busy = 1'b1;
`ifdef PERM_CHECK_EN
        if (!is_perm(bus.seq_all)) m_perm = 1'b1;
`endif
      end
    end else if (!bus.req[m_win]) begin
      m_busy = 1'b0;
    end else if (bus.out_ready) begin
      if (m_idx == 15) begin
        m_busy = 1'b0;
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
      end else begin
        m_idx++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_gnt",   bus.gnt,       m_busy ? (64'd1 << m_win) : 64'd0);
      chk("m_valid", bus.out_valid, m_busy);
      chk("m_busy",  bus.busy,      m_busy);
      chk("m_idx",   bus.out_idx,   m_busy ? m_idx : 0);
      chk("m_data",  bus.out_data,  m_busy ? m_snap[4*m_idx +: 4] : 4'd0);
      chk("m_last",  bus.out_last,  m_busy && (m_idx == 15));
      chk("m_cnt",   bus.deal_cnt,  m_cnt);
      chk("m_perr",  bus.perm_err,  m_perm);
    end
  end

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 8 && !ok; c++) begin
      @(negedge clk);
      if (bus.busy) ok = 1'b1;
    end
    chk({tag, "_grant_timeout"}, ok, 1'b1);
  endtask

  // Runs to out_last, then to the first idle cycle after the final handshake.
  task automatic finish_deal(input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      if (bus.out_last) ok = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_last_timeout"}, ok, 1'b1);
    @(negedge clk);
    chk({tag, "_idle_gnt"}, bus.gnt, 0);
    chk({tag, "_idle_busy"}, bus.busy, 0);
  endtask

  task automatic run_deal(input logic [3:0] exp_gnt, input string tag);
    wait_busy(tag);
    chk({tag, "_gnt"}, bus.gnt, exp_gnt);
    finish_deal(tag);
  endtask

  initial begin
    bus.req = '0; bus.out_ready = 1'b0; bus.seq_all = P_GOOD;
    repeat (3) @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt", bus.deal_cnt, 0);
    chk("rst_perr", bus.perm_err, 0);
    rst = 1'b0;

    // Single requester, continuous ready: elements 0..F, last on the 16th.
    bus.req = 4'b0001; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t1_gnt", bus.gnt, 4'b0001);
    for (int i = 0; i < 16; i++) begin
      chk("t1_data", bus.out_data, i);
      chk("t1_last", bus.out_last, i == 15);
      if (i < 15) @(negedge clk);
    end
    @(negedge clk);
    chk("t1_cnt", bus.deal_cnt, 1);
    chk("t1_idle_gnt", bus.gnt, 0);
    bus.req = '0;

    // All requesting: strict rotation from requester 0.
    pulse_rst();
    bus.req = 4'b1111;
    for (int d = 0; d < 4; d++) run_deal(4'(1 << d), "t2");
    bus.req = '0;
    chk("t2_cnt", bus.deal_cnt, 4);

    // Back-pressure and mid-deal seq_all change.
    bus.req = 4'b0001;
    wait_busy("t3");
    chk("t3_d0", bus.out_data, 4'h0);
    @(negedge clk);
    chk("t3_i1", bus.out_idx, 1);
    bus.out_ready = 1'b0; bus.seq_all = P_ALT;
    repeat (2) begin
      @(negedge clk);
      chk("t3_hold_idx", bus.out_idx, 1);
      chk("t3_hold_data", bus.out_data, 4'h1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_i2", bus.out_idx, 2);
    chk("t3_d2", bus.out_data, 4'h2);
    finish_deal("t3");
    bus.req = '0; bus.seq_all = P_GOOD;
    chk("t3_cnt", bus.deal_cnt, 5);

    // Abort at element 5, then a fresh deal restarts at 0.
    bus.req = 4'b0001;
    wait_busy("t4");
    for (int c = 0; c < 20 && bus.out_idx != 4'd5; c++) @(negedge clk);
    chk("t4_at5", bus.out_idx, 5);
    bus.req = '0;
    @(negedge clk);
    chk("t4_busy", bus.busy, 0);
    chk("t4_gnt", bus.gnt, 0);
    chk("t4_valid", bus.out_valid, 0);
    chk("t4_last", bus.out_last, 0);
    chk("t4_cnt", bus.deal_cnt, 5);
    bus.req = 4'b0001;
    wait_busy("t4r");
    chk("t4_restart_idx", bus.out_idx, 0);
    finish_deal("t4r");
    bus.req = '0;
    chk("t4_cnt2", bus.deal_cnt, 6);

    // Counter wrap, then asynchronous reset mid-stream.
    bus.req = 4'b0001;
    for (int n = 0; n < 9; n++) run_deal(4'b0001, "t5");
    chk("t5_cnt_max", bus.deal_cnt, 15);
    run_deal(4'b0001, "t5w");
    bus.req = '0;
    chk("t5_wrap", bus.deal_cnt, 0);
    bus.req = 4'b0001;
    wait_busy("t5r");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_gnt", bus.gnt, 0);
    chk("t5_rst_valid", bus.out_valid, 0);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_idx", bus.out_idx, 0);
    chk("t5_rst_data", bus.out_data, 0);
    chk("t5_rst_last", bus.out_last, 0);
    @(negedge clk);
    bus.req = '0;
    rst = 1'b0;

    // Snapshot checker: bad capture latches, good capture does not clear.
    bus.seq_all = P_BAD; bus.req = 4'b0001;
    wait_busy("t6a");
    chk("t6_bad_perr", bus.perm_err, EXP_BAD_PE);
    finish_deal("t6a");
    bus.req = '0; bus.seq_all = P_GOOD;
    @(negedge clk);
    bus.req = 4'b0001;
    wait_busy("t6b");
    chk("t6_sticky_perr", bus.perm_err, EXP_BAD_PE);
    finish_deal("t6b");
    bus.req = '0;
    pulse_rst();
    chk("t6_rst_perr", bus.perm_err, 0);
    bus.req = 4'b0001;
    wait_busy("t6c");
    chk("t6_good_perr", bus.perm_err, 0);
    finish_deal("t6c");
    bus.req = '0;

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
